// File: rtl/fpga_fabric_v1_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fpga_fabric_v1_if
// Description : Serial configuration bus of the fabric (data in, shift strobe,
//               mode enable, chain output).
// Revision    : 1.0 - initial release
// ============================================================================
interface fpga_fabric_v1_if;
   logic prog_in;
   logic prog_clk;
   logic prog_en;
   logic prog_out;

   modport master (output prog_in, output prog_clk, output prog_en, input prog_out);
   modport slave  (input prog_in, input prog_clk, input prog_en, output prog_out);
endinterface
`default_nettype wire

// File: rtl/fpga_fabric_v1.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fpga_fabric_v1
// Description : Minimal programmable fabric - 4 BLEs (4-LUT + optional
//               clock-enabled FF) and 16 tri-state pads, configured through a
//               daisy-chainable 224-bit serial shift chain.
// Revision    : 1.0 - initial release
// ============================================================================
module fpga_fabric_v1 #(
   parameter int CFG_BITS = 224
) (
   input  logic                   clk,
   input  logic                   rst,
   fpga_fabric_v1_if.slave        cfg_bus,
   inout  wire  [15:0]            io
);

   localparam int NUM_BLE   = 4;
   localparam int NUM_PAD   = 16;
   localparam int BLE_STEP  = 42;
   localparam int PAD_BASE  = 168;

   logic [CFG_BITS-1:0] r_cfg;
   logic                r_prog_clk_d;
   logic [NUM_BLE-1:0]  r_q;
   logic                w_shift;

   logic [15:0]         w_tt     [NUM_BLE];
   logic [4:0]          w_in_sel [NUM_BLE][4];
   logic [4:0]          w_ce_sel [NUM_BLE];
   logic [NUM_BLE-1:0]  w_use_ff;
   logic [NUM_BLE-1:0]  w_lut;
   logic [NUM_BLE-1:0]  w_q_d;

   logic [NUM_PAD-1:0]  w_pad_oe;
   logic [1:0]          w_pad_sel [NUM_PAD];
   logic [NUM_PAD-1:0]  w_pad_val;

   // prog_clk is a strobe sampled in the clk domain; a shift needs a rising edge
   assign w_shift          = cfg_bus.prog_en & cfg_bus.prog_clk & ~r_prog_clk_d;
   assign cfg_bus.prog_out = r_cfg[0];

   // Configuration chain and strobe edge detector
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cfg        <= '0;
         r_prog_clk_d <= 1'b0;
      end else begin
         r_prog_clk_d <= cfg_bus.prog_clk;
         if (w_shift) begin
            r_cfg <= {cfg_bus.prog_in, r_cfg[CFG_BITS-1:1]};
         end
      end
   end

   // Unpack the per-BLE configuration fields
   generate
      for (genvar k = 0; k < NUM_BLE; k++) begin : g_ble_cfg
         assign w_tt[k]     = r_cfg[BLE_STEP*k +: 16];
         for (genvar j = 0; j < 4; j++) begin : g_in_sel
            assign w_in_sel[k][j] = r_cfg[BLE_STEP*k + 16 + 5*j +: 5];
         end
         assign w_ce_sel[k] = r_cfg[BLE_STEP*k + 36 +: 5];
         assign w_use_ff[k] = r_cfg[BLE_STEP*k + 41];
      end
   endgenerate

   // Unpack pad fields and drive the pads; config mode forces every pad hi-Z
   generate
      for (genvar p = 0; p < NUM_PAD; p++) begin : g_pad
         assign w_pad_oe[p]  = r_cfg[PAD_BASE + 3*p] & ~cfg_bus.prog_en;
         assign w_pad_sel[p] = r_cfg[PAD_BASE + 3*p + 1 +: 2];
         assign io[p]        = w_pad_oe[p] ? w_pad_val[p] : 1'bz;
      end
   endgenerate

   // 5-bit source selector: pads, BLE outputs, constants
   function automatic logic pick_src(input logic [4:0]  sel,
                                     input logic [15:0] pads,
                                     input logic [3:0]  bles);
      logic r;
      if (sel < 5'd16)      r = pads[sel[3:0]];
      else if (sel < 5'd20) r = bles[sel[1:0]];
      else                  r = (sel == 5'd21);
      return r;
   endfunction

   // LUT network: evaluated in NUM_BLE passes so any legal chain of
   // combinational BLEs (also routed through own pads) settles, while an
   // illegal loop still yields a deterministic, non-oscillating result
   always_comb begin
      logic [NUM_BLE-1:0] cur;
      logic [NUM_BLE-1:0] nxt;
      logic [NUM_PAD-1:0] pin;
      logic [3:0]         idx;
      cur       = r_q & w_use_ff;
      nxt       = cur;
      pin       = '0;
      idx       = '0;
      w_lut     = '0;
      w_pad_val = '0;
      w_q_d     = r_q;
      for (int pass = 0; pass < NUM_BLE; pass++) begin
         for (int p = 0; p < NUM_PAD; p++) begin
            pin[p] = w_pad_oe[p] ? cur[w_pad_sel[p]] : io[p];
         end
         for (int k = 0; k < NUM_BLE; k++) begin
            for (int j = 0; j < 4; j++) begin
               idx[j] = pick_src(w_in_sel[k][j], pin, cur);
            end
            w_lut[k] = w_tt[k][idx];
            nxt[k]   = w_use_ff[k] ? r_q[k] : w_lut[k];
         end
         cur = nxt;
      end
      for (int p = 0; p < NUM_PAD; p++) begin
         w_pad_val[p] = cur[w_pad_sel[p]];
         pin[p]       = w_pad_oe[p] ? w_pad_val[p] : io[p];
      end
      for (int k = 0; k < NUM_BLE; k++) begin
         if (pick_src(w_ce_sel[k], pin, cur) && !cfg_bus.prog_en) begin
            w_q_d[k] = w_lut[k];
         end
      end
   end

   // BLE flip-flops
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
      end else begin
         r_q <= w_q_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fpga_fabric_v1.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fpga_fabric_v1
// Description : Directed bench for fpga_fabric_v1 - chain shifting, pad hi-Z,
//               4-bit counter configuration with enable, hold and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpga_fabric_v1;

   logic        clk = 1'b0;
   logic        rst;
   wire  [15:0] io;
   logic [15:0] drv_en;
   logic [15:0] drv_val;

   int vectors     = 0;
   int miscompares = 0;

   logic [223:0] pat_a;
   logic [223:0] pat_b;
   logic [223:0] cnt_cfg;
   logic [223:0] zeros;
   logic [15:0]  lut_tab [4];
   logic [31:0]  exp_cnt;

   fpga_fabric_v1_if bus ();

   always #5 clk = ~clk;

   generate
      for (genvar p = 0; p < 16; p++) begin : g_drv
         assign io[p] = drv_en[p] ? drv_val[p] : 1'bz;
      end
   endgenerate

   fpga_fabric_v1 #(.CFG_BITS(224)) dut (
      .clk     (clk),
      .rst     (rst),
      .cfg_bus (bus.slave),
      .io      (io)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Shift v in (bit 0 first), checking prog_out against exp_out before each strobe
   task automatic load(input logic [223:0] v, input logic [223:0] exp_out, input string tag);
      for (int i = 0; i < 224; i++) begin
         @(negedge clk);
         check(tag, {31'd0, bus.prog_out}, {31'd0, exp_out[i]});
         bus.prog_in  = v[i];
         bus.prog_clk = 1'b1;
         @(negedge clk);
         bus.prog_clk = 1'b0;
      end
   endtask

   // Pads in mask must follow whatever the bench forces on them
   task automatic check_hiz(input logic [15:0] mask, input string tag);
      logic [15:0] sv_en;
      logic [15:0] sv_val;
      sv_en   = drv_en;
      sv_val  = drv_val;
      drv_en  = drv_en | mask;
      drv_val = (sv_val & ~mask) | (16'hA5C3 & mask);
      #1;
      check(tag, {16'd0, io & mask}, {16'd0, 16'hA5C3 & mask});
      drv_val = (sv_val & ~mask) | (16'h5A3C & mask);
      #1;
      check(tag, {16'd0, io & mask}, {16'd0, 16'h5A3C & mask});
      drv_en  = sv_en;
      drv_val = sv_val;
   endtask

   task automatic cnt_step(input logic inc, input string tag);
      @(negedge clk);
      if (inc) exp_cnt = (exp_cnt + 1) % 16;
      #1;
      check(tag, {28'd0, io[14:11]}, exp_cnt);
   endtask

   initial begin
      rst          = 1'b1;
      bus.prog_in  = 1'b0;
      bus.prog_clk = 1'b0;
      bus.prog_en  = 1'b0;
      drv_en       = 16'h0001;
      drv_val      = 16'h0000;
      zeros        = '0;
      exp_cnt      = 0;
      for (int w = 0; w < 7; w++) begin
         pat_a[32*w +: 32] = $urandom;
         pat_b[32*w +: 32] = $urandom;
      end

      // Counter configuration: LUT_k = q_k ^ &q[k-1:0]
      lut_tab[0] = 16'h5555;
      lut_tab[1] = 16'h6666;
      lut_tab[2] = 16'h7878;
      lut_tab[3] = 16'h7F80;
      cnt_cfg = '0;
      for (int k = 0; k < 4; k++) begin
         cnt_cfg[42*k      +: 16] = lut_tab[k];
         cnt_cfg[42*k + 16 +: 5]  = 5'd16;
         cnt_cfg[42*k + 21 +: 5]  = 5'd17;
         cnt_cfg[42*k + 26 +: 5]  = 5'd18;
         cnt_cfg[42*k + 31 +: 5]  = 5'd19;
         cnt_cfg[42*k + 36 +: 5]  = 5'd0;
         cnt_cfg[42*k + 41]       = 1'b1;
      end
      for (int p = 11; p <= 14; p++) begin
         cnt_cfg[168 + 3*p]      = 1'b1;
         cnt_cfg[168 + 3*p + 1 +: 2] = 2'(p - 11);
      end

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_prog_out", {31'd0, bus.prog_out}, 32'd0);
      check_hiz(16'hFFFF, "reset_hiz");

      // Chain: A then B then counter; prog_out replays the previous load
      bus.prog_en = 1'b1;
      load(pat_a, zeros, "load_a_out");
      load(pat_b, pat_a, "load_b_out");
      #1;
      check_hiz(16'hFFFE, "prog_en_hiz");
      load(cnt_cfg, pat_b, "load_c_out");

      // Counter run with wrap
      bus.prog_en = 1'b0;
      drv_val[0]  = 1'b1;
      #1;
      check("cnt_start", {28'd0, io[14:11]}, 32'd0);
      for (int j = 0; j < 16; j++) cnt_step(1'b1, "cnt_run");
      for (int j = 0; j < 5; j++)  cnt_step(1'b1, "cnt_run2");

      // Enable low freezes the count, then resumes
      drv_val[0] = 1'b0;
      for (int j = 0; j < 8; j++) cnt_step(1'b0, "cnt_frozen");
      drv_val[0] = 1'b1;
      for (int j = 0; j < 3; j++) cnt_step(1'b1, "cnt_resume");

      // prog_en mid-count: hold and hi-Z, then resume without strobes
      bus.prog_en = 1'b1;
      check_hiz(16'h7800, "cnt_pen_hiz");
      repeat (4) @(negedge clk);
      #1;
      check_hiz(16'h7800, "cnt_pen_hiz2");
      bus.prog_en = 1'b0;
      #1;
      check("cnt_pen_hold", {28'd0, io[14:11]}, exp_cnt);
      for (int j = 0; j < 2; j++) cnt_step(1'b1, "cnt_pen_resume");

      // Reset mid-count clears everything
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_hiz(16'h7800, "rst_hiz");
      check("rst_prog_out", {31'd0, bus.prog_out}, 32'd0);
      bus.prog_en = 1'b1;
      load(zeros, zeros, "rst_cfg_zero");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
